// File: rtl/flag_pulse_monitor.sv
// Measures the high-time of each flag_in pulse and queues the widths in a FIFO read over valid/ready.
// Optional glitch filter: define FLAG_MON_GLITCH_FILTER_EN to drop pulses shorter than MIN_WIDTH.
module flag_pulse_monitor #(
    parameter int CNT_W     = 8,
    parameter int DEPTH     = 4,
    parameter int MIN_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flag_in,
    input  logic                     clr,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [CNT_W-1:0]         rd_width,
    output logic                     ovf,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and >= 2");
    end
    if (MIN_WIDTH < 1 || MIN_WIDTH > (2 ** CNT_W) - 1) begin : g_bad_min_width
        $error("MIN_WIDTH must be in 1 .. 2**CNT_W-1");
    end

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        MEASURE
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              full;
    logic              do_push;
    logic              drop;

    logic [CNT_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= WAIT_LOW;
            cnt   <= '0;
        end else if (clr) begin
            state <= WAIT_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        push_req = 1'b0;
        case (state)
            WAIT_LOW: begin
                if (!flag_in) state_nx = IDLE;
            end
            IDLE: begin
                if (flag_in) begin
                    cnt_nx   = CNT_W'(1);
                    state_nx = MEASURE;
                end
            end
            MEASURE: begin
                if (flag_in) begin
                    cnt_nx = (cnt == '1) ? cnt : cnt + 1'b1;
                end else begin
                    push_req = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = WAIT_LOW;
        endcase
    end

`ifdef FLAG_MON_GLITCH_FILTER_EN
    // Filtered pulses are discarded before the FIFO, so they can never raise ovf.
    assign push = push_req && (cnt >= CNT_W'(MIN_WIDTH));
`else
    assign push = push_req;
`endif

    assign busy     = (state == MEASURE);
    assign rd_valid = (level != '0);
    assign rd_width = mem[rd_ptr];
    assign full     = (level == LW'(DEPTH));
    assign pop      = rd_valid && rd_ready;
    assign do_push  = push && (!full || pop);
    assign drop     = push && full && !pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= cnt;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)      level <= level + 1'b1;
            else if (pop && !do_push) level <= level - 1'b1;
            if (drop) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_flag_pulse_monitor.sv
// Scoreboard bench for flag_pulse_monitor: stimulus queues expected widths, a negedge monitor checks pops.
module tb_flag_pulse_monitor;

    localparam int CNT_W = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rstn;
    logic             flag_in;
    logic             clr;
    logic             rd_ready;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_width;
    logic             ovf;
    logic             busy;
    logic [LW-1:0]    level;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int exp_q[$];

    flag_pulse_monitor #(.CNT_W(CNT_W), .DEPTH(DEPTH), .MIN_WIDTH(2)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .flag_in  (flag_in),
        .clr      (clr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_width (rd_width),
        .ovf      (ovf),
        .busy     (busy),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted head entry must match the oldest expected width.
    always @(negedge clk) begin
        if (rstn && rd_valid && rd_ready) begin
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0d expected no entry", rd_width);
            end else begin
                if (int'(rd_width) != exp_q[0]) begin
                    errors++;
                    $display("FAIL pop_width: got %0d expected %0d", rd_width, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n high samples, then one low sample (the push edge).
    task automatic pulse(input int n);
        flag_in = 1'b1;
        repeat (n) tick();
        flag_in = 1'b0;
        tick();
    endtask

    task automatic drain();
        int k;
        rd_ready = 1'b1;
        for (k = 0; k < 20; k++) begin
            tick();
            if (level == '0) break;
        end
        rd_ready = 1'b0;
        chk("drain_level", int'(level), 0);
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
    endtask

    initial begin
        rstn     = 1'b0;
        flag_in  = 1'b0;
        clr      = 1'b0;
        rd_ready = 1'b0;
        #22;
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_width", int'(rd_width), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_level", int'(level), 0);
        rstn = 1'b1;
        tick();

        // 5-cycle pulse
        flag_in = 1'b1;
        tick();
        chk("busy_rise", int'(busy), 1);
        repeat (4) tick();
        flag_in = 1'b0;
        chk("no_push_before_fall", int'(level), 0);
        tick();
        exp_q.push_back(5);
        chk("t1_rd_valid", int'(rd_valid), 1);
        chk("t1_rd_width", int'(rd_width), 5);
        chk("t1_level", int'(level), 1);
        chk("t1_ovf", int'(ovf), 0);
        chk("t1_busy_fall", int'(busy), 0);
        drain();

        // five 3-cycle pulses into a 4-deep FIFO
        for (int i = 0; i < 4; i++) begin
            pulse(3);
            exp_q.push_back(3);
        end
        chk("fill_level", int'(level), 4);
        chk("fill_ovf", int'(ovf), 0);
        pulse(3);
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_level", int'(level), 4);
        chk("ovf_head", int'(rd_width), 3);
        pops = 0;
        drain();
        chk("ovf_drain_count", pops, 4);
        chk("ovf_sticky", int'(ovf), 1);
        do_clr();
        chk("clr_ovf", int'(ovf), 0);

        // push coinciding with pop on a full FIFO
        for (int w = 2; w <= 5; w++) begin
            pulse(w);
            exp_q.push_back(w);
        end
        chk("full2_level", int'(level), 4);
        flag_in = 1'b1;
        repeat (6) tick();
        flag_in  = 1'b0;
        rd_ready = 1'b1;
        exp_q.push_back(6);
        tick();
        rd_ready = 1'b0;
        chk("pushpop_level", int'(level), 4);
        chk("pushpop_ovf", int'(ovf), 0);
        chk("pushpop_head", int'(rd_width), 3);
        drain();

        // saturation
        pulse(300);
        exp_q.push_back(255);
        chk("sat_width", int'(rd_width), 255);
        chk("sat_level", int'(level), 1);
        drain();

        // clr mid-pulse
        flag_in = 1'b1;
        tick();
        tick();
        chk("clr_pre_busy", int'(busy), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_busy", int'(busy), 0);
        repeat (4) tick();
        chk("clr_wait_low_busy", int'(busy), 0);
        flag_in = 1'b0;
        tick();
        chk("clr_level", int'(level), 0);
        chk("clr_ovf2", int'(ovf), 0);
        pulse(2);
        exp_q.push_back(2);
        chk("after_clr_width", int'(rd_width), 2);
        chk("after_clr_level", int'(level), 1);
        drain();

        // 1-cycle pulse: filtered or recorded depending on the build
        pulse(1);
`ifdef FLAG_MON_GLITCH_FILTER_EN
        chk("glitch_level", int'(level), 0);
`else
        exp_q.push_back(1);
        chk("glitch_level", int'(level), 1);
        chk("glitch_width", int'(rd_width), 1);
`endif
        chk("glitch_ovf", int'(ovf), 0);
        pulse(2);
        exp_q.push_back(2);
        drain();

        // async reset mid-pulse with a stored entry
        pulse(3);
        chk("pre_rst_level", int'(level), 1);
        flag_in = 1'b1;
        tick();
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_rd_valid", int'(rd_valid), 0);
        chk("arst_rd_width", int'(rd_width), 0);
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        chk("arst_wait_low", int'(busy), 0);
        flag_in = 1'b0;
        tick();
        pulse(4);
        exp_q.push_back(4);
        chk("arst_after_width", int'(rd_width), 4);
        drain();

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
